// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings and FSM state type shared by the multiply/divide engine.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

endpackage

// File: rtl/muldiv_abs.sv
// muldiv_abs: two's-complement conditional negate, used both for operand magnitudes and result sign fix-up.
module muldiv_abs #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic         neg,
    output logic [W-1:0] y
);

    assign y = neg ? W'(-a) : a;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 MULT/MULTU/DIV/DIVU engine producing HI/LO.
// One step per clock on unsigned magnitudes; signs are applied in the FIX cycle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opr_a,
    input  logic [WIDTH-1:0] opr_b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t             state;
    logic [1:0]         op_r;
    logic               sa, sb;
    logic [CNT_W-1:0]   count;
    logic [2*WIDTH-1:0] acc, p_fix;
    logic [WIDTH-1:0]   b_reg, a_raw, abs_a, abs_b, q_fix, r_fix;
    logic [WIDTH:0]     sum;
    logic [WIDTH+1:0]   trial;

    muldiv_abs #(.W(WIDTH))   u_abs_a (.a(opr_a), .neg(~op[0] & opr_a[WIDTH-1]), .y(abs_a));
    muldiv_abs #(.W(WIDTH))   u_abs_b (.a(opr_b), .neg(~op[0] & opr_b[WIDTH-1]), .y(abs_b));
    muldiv_abs #(.W(2*WIDTH)) u_fix_p (.a(acc), .neg(sa ^ sb), .y(p_fix));
    muldiv_abs #(.W(WIDTH))   u_fix_q (.a(acc[WIDTH-1:0]), .neg(sa ^ sb), .y(q_fix));
    muldiv_abs #(.W(WIDTH))   u_fix_r (.a(acc[2*WIDTH-1:WIDTH]), .neg(sa), .y(r_fix));

    // multiply: {hi_partial, multiplier} shifts right; divide: {rem, quo} shifts left
    assign sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_reg} : '0);
    assign trial = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, b_reg};

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            op_r        <= OP_MULT;
            sa          <= 1'b0;
            sb          <= 1'b0;
            count       <= '0;
            acc         <= '0;
            b_reg       <= '0;
            a_raw       <= '0;
        end else begin
            done <= 1'b0;
            if (busy && cancel) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start && !cancel) begin
                        state       <= CALC;
                        busy        <= 1'b1;
                        op_r        <= op;
                        sa          <= ~op[0] & opr_a[WIDTH-1];
                        sb          <= ~op[0] & opr_b[WIDTH-1];
                        acc         <= {{WIDTH{1'b0}}, abs_a};
                        b_reg       <= abs_b;
                        a_raw       <= opr_a;
                        count       <= '0;
                        div_by_zero <= 1'b0;
                    end
                    CALC: begin
                        count <= count + 1'b1;
                        acc   <= op_r[1] ? (trial[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0}
                                                           : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                                         : {sum, acc[WIDTH-1:1]};
                        if (count == CNT_W'(WIDTH - 1)) state <= FIX;
                    end
                    FIX: begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        div_by_zero <= op_r[1] && b_reg == '0;
                        hi          <= !op_r[1] ? p_fix[2*WIDTH-1:WIDTH] : (b_reg == '0 ? a_raw : r_fix);
                        lo          <= !op_r[1] ? p_fix[WIDTH-1:0] : (b_reg == '0 ? '1 : q_fix);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit at WIDTH=32.
// Expected HI/LO come from a behavioural 64-bit arithmetic model queued at issue time.
module tb_muldiv_unit;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    logic        clk, reset, start, cancel;
    logic [1:0]  op;
    logic [31:0] opr_a, opr_b;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;

    int   tests, fails, lat, busy_cyc;
    exp_t sb_q[$];

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .opr_a(opr_a), .opr_b(opr_b),
        .cancel(cancel), .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb;
        logic [63:0] p;
        exp_t       e;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e.dbz = 1'b0;
        if (o == 2'b00)       p = 64'(sa * sb);
        else if (o == 2'b01)  p = {32'b0, a} * {32'b0, b};
        else if (b == 32'b0) begin
            p = {a, 32'hFFFFFFFF};
            e.dbz = 1'b1;
        end
        else if (o[0])        p = {a % b, a / b};
        else                  p = {32'(sa % sb), 32'(sa / sb)};
        e.hi = p[63:32];
        e.lo = p[31:0];
        return e;
    endfunction

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit push);
        op = o;
        opr_a = a;
        opr_b = b;
        start = 1'b1;
        if (push) sb_q.push_back(model(o, a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        lat = 0;
        busy_cyc = busy ? 1 : 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busy_cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        cancel = 1'b0;
        op = 2'b00;
        opr_a = '0;
        opr_b = '0;
        repeat (2) @(posedge clk);
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
        tests++; if (hi !== 32'h0) begin fails++; $display("FAIL reset_hi: got %h want 0", hi); end
        tests++; if (lo !== 32'h0) begin fails++; $display("FAIL reset_lo: got %h want 0", lo); end
        reset = 1'b1;
    endtask

    task automatic test_mult_back_to_back();
        exp_t e;
        issue(2'b00, 32'hFFFFFFFD, 32'h00000007, 1'b1);
        wait_done();
        e = sb_q.pop_front();
        tests++; if (lat !== 33) begin fails++; $display("FAIL mult_latency: got %0d want 33", lat); end
        tests++; if (busy_cyc !== 33) begin fails++; $display("FAIL mult_busy_cycles: got %0d want 33", busy_cyc); end
        tests++; if (hi !== e.hi || lo !== e.lo) begin fails++; $display("FAIL mult_result: got %h_%h want %h_%h", hi, lo, e.hi, e.lo); end
        issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_accept: busy got %b want 1", busy); end
        wait_done();
        e = sb_q.pop_front();
        tests++; if (lat !== 33) begin fails++; $display("FAIL multu_latency: got %0d want 33", lat); end
        tests++; if (hi !== e.hi || lo !== e.lo) begin fails++; $display("FAIL multu_result: got %h_%h want %h_%h", hi, lo, e.hi, e.lo); end
    endtask

    task automatic test_div();
        logic [1:0]  ops[5] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b10};
        logic [31:0] as[5]  = '{32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd5, 32'hFFFFFFF9};
        logic [31:0] bs[5]  = '{32'd2, 32'd2, 32'hFFFFFFFF, 32'd0, 32'd0};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            issue(ops[i], as[i], bs[i], 1'b1);
            wait_done();
            e = sb_q.pop_front();
            tests++; if (lat !== 33) begin fails++; $display("FAIL div%0d_latency: got %0d want 33", i, lat); end
            tests++; if (hi !== e.hi || lo !== e.lo) begin fails++; $display("FAIL div%0d_result: got %h_%h want %h_%h", i, hi, lo, e.hi, e.lo); end
            tests++; if (div_by_zero !== e.dbz) begin fails++; $display("FAIL div%0d_dbz: got %b want %b", i, div_by_zero, e.dbz); end
        end
    endtask

    task automatic test_cancel();
        logic [31:0] phi, plo;
        int          k[2] = '{10, 33};
        int          seen;
        exp_t        e;
        phi = hi;
        plo = lo;
        for (int j = 0; j < 2; j++) begin
            issue(2'b10, 32'd1000, 32'd3, 1'b0);
            if (j == 0) begin
                tests++; if (div_by_zero !== 1'b0) begin fails++; $display("FAIL dbz_clear_on_start: got %b want 0", div_by_zero); end
            end
            for (int i = 1; i < k[j]; i++) begin @(posedge clk); #1; end
            cancel = 1'b1;
            @(posedge clk);
            #1;
            cancel = 1'b0;
            tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL cancel%0d_state: got busy=%b done=%b want 0 0", k[j], busy, done); end
            tests++; if (hi !== phi || lo !== plo) begin fails++; $display("FAIL cancel%0d_hold: got %h_%h want %h_%h", k[j], hi, lo, phi, plo); end
            seen = 0;
            for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (done) seen++; end
            tests++; if (seen !== 0) begin fails++; $display("FAIL cancel%0d_no_done: got %0d pulses want 0", k[j], seen); end
        end
        issue(2'b11, 32'd100, 32'd7, 1'b1);
        for (int i = 0; i < 5; i++) begin
            start = (i >= 2);
            op = 2'b00;
            opr_a = 32'h12345678;
            opr_b = 32'h9ABCDEF0;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        wait_done();
        e = sb_q.pop_front();
        tests++; if (lat !== 28) begin fails++; $display("FAIL ignore_start_latency: got %0d want 28", lat); end
        tests++; if (hi !== e.hi || lo !== e.lo) begin fails++; $display("FAIL ignore_start_result: got %h_%h want %h_%h", hi, lo, e.hi, e.lo); end
        @(posedge clk);
        #1;
        cancel = 1'b1;
        issue(2'b00, 32'd3, 32'd3, 1'b0);
        cancel = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL cancel_start_idle: busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        issue(2'b00, 32'h0000ABCD, 32'h00001234, 1'b0);
        for (int i = 1; i < 20; i++) begin @(posedge clk); #1; end
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        tests++; if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin fails++; $display("FAIL midreset_ctrl: got busy=%b done=%b dbz=%b want 0 0 0", busy, done, div_by_zero); end
        tests++; if (hi !== 32'h0 || lo !== 32'h0) begin fails++; $display("FAIL midreset_hilo: got %h_%h want 0_0", hi, lo); end
        issue(2'b00, 32'h00001234, 32'hFFFFFFFB, 1'b1);
        wait_done();
        e = sb_q.pop_front();
        tests++; if (lat !== 33) begin fails++; $display("FAIL postreset_latency: got %0d want 33", lat); end
        tests++; if (hi !== e.hi || lo !== e.lo) begin fails++; $display("FAIL postreset_result: got %h_%h want %h_%h", hi, lo, e.hi, e.lo); end
    endtask

    task automatic test_random();
        exp_t e;
        issue(2'($urandom_range(0, 3)), $urandom, $urandom, 1'b1);
        for (int i = 0; i < 10; i++) begin
            wait_done();
            e = sb_q.pop_front();
            tests++; if (hi !== e.hi || lo !== e.lo || div_by_zero !== e.dbz) begin fails++; $display("FAIL random%0d: got %h_%h dbz=%b want %h_%h dbz=%b", i, hi, lo, div_by_zero, e.hi, e.lo, e.dbz); end
            if (i < 9) issue(2'($urandom_range(0, 3)), $urandom,
                             ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom, 1'b1);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_mult_back_to_back();
        test_div();
        test_cancel();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
